// File: rtl/branch_predict_unit.sv
// D-stage branch resolution plus a direct-mapped BTB of saturating counters.
// F stage looks up taken/target for f_pc; D stage resolves, flags mispredict and trains.
module branch_predict_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       f_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              d_is_br,
  input  logic              d_stall,
  input  logic [31:0]       d_pc,
  input  logic [5:0]        d_opcode,
  input  logic [4:0]        d_rt,
  input  logic [WIDTH-1:0]  d_rd1,
  input  logic [WIDTH-1:0]  d_rd2,
  input  logic [31:0]       d_target,
  input  logic              d_pred_taken,
  input  logic [31:0]       d_pred_target,
  output logic              br,
  output logic              mispredict,
  output logic [31:0]       redirect_pc
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;

  logic             valid_q  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [CNT_W-1:0] cnt_q    [DEPTH];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] d_idx;
  logic [TAG_W-1:0] d_tag;
  logic             d_hit;
  logic             cond;
  logic             known;
  logic             rd1_zero;
  logic             rd1_neg;
  logic             train;
  logic             write_en;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_next;
  logic             unused_ok;

  assign f_idx     = f_pc[IDX_W+1:2];
  assign f_tag     = f_pc[31:IDX_W+2];
  assign d_idx     = d_pc[IDX_W+1:2];
  assign d_tag     = d_pc[31:IDX_W+2];
  assign unused_ok = ^f_pc[1:0];

  // Fetch lookup straight from the table registers; no bypass of same-cycle writes.
  always_comb begin
    pred_taken  = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && cnt_q[f_idx][CNT_W-1];
    pred_target = pred_taken ? target_q[f_idx] : 32'd0;
  end

  assign rd1_zero = (d_rd1 == '0);
  assign rd1_neg  = d_rd1[WIDTH-1];

  always_comb begin
    cond  = 1'b0;
    known = 1'b0;
    case (d_opcode)
      OP_BEQ:  begin known = 1'b1; cond = (d_rd1 == d_rd2); end
      OP_BNE:  begin known = 1'b1; cond = (d_rd1 != d_rd2); end
      OP_BLEZ: begin known = 1'b1; cond = rd1_zero || rd1_neg; end
      OP_BGTZ: begin known = 1'b1; cond = !rd1_zero && !rd1_neg; end
      OP_REGIMM: begin
        if (d_rt == RT_BLTZ) begin
          known = 1'b1;
          cond  = rd1_neg;
        end else if (d_rt == RT_BGEZ) begin
          known = 1'b1;
          cond  = !rd1_neg;
        end
      end
      default: ;
    endcase
  end

  // Redirect to the target when taken, otherwise past the delay slot.
  always_comb begin
    br          = d_is_br && cond;
    mispredict  = d_is_br && ((br != d_pred_taken) ||
                              (br && d_pred_taken && (d_pred_target != d_target)));
    redirect_pc = br ? d_target : d_pc + 32'd8;
  end

  assign d_hit    = valid_q[d_idx] && (tag_q[d_idx] == d_tag);
  assign cnt_cur  = cnt_q[d_idx];
  assign train    = d_is_br && !d_stall && known;
  assign write_en = train && (br || d_hit);

  // Saturating counter update; a taken miss allocates as weakly taken.
  always_comb begin
    cnt_next = cnt_cur;
    if (br) begin
      if (!d_hit)
        cnt_next = CNT_WEAK_T;
      else if (cnt_cur != CNT_MAX)
        cnt_next = cnt_cur + CNT_W'(1);
    end else if (cnt_cur != '0) begin
      cnt_next = cnt_cur - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WEAK_NT;
      end
    end else if (write_en) begin
      cnt_q[d_idx] <= cnt_next;
      if (br) begin
        valid_q[d_idx]  <= 1'b1;
        tag_q[d_idx]    <= d_tag;
        target_q[d_idx] <= d_target;
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit against a behavioural BTB model.
module tb_branch_predict_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 64;
  localparam int CNT_W = 2;
  localparam int IDX_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int HALF  = 1 << (CNT_W - 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       f_pc = '0;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic              d_is_br = 1'b0;
  logic              d_stall = 1'b0;
  logic [31:0]       d_pc = '0;
  logic [5:0]        d_opcode = '0;
  logic [4:0]        d_rt = '0;
  logic [WIDTH-1:0]  d_rd1 = '0;
  logic [WIDTH-1:0]  d_rd2 = '0;
  logic [31:0]       d_target = '0;
  logic              d_pred_taken = 1'b0;
  logic [31:0]       d_pred_target = '0;
  logic              br;
  logic              mispredict;
  logic [31:0]       redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid  [DEPTH];
  logic [31:0] m_tag    [DEPTH];
  logic [31:0] m_target [DEPTH];
  int          m_cnt    [DEPTH];

  branch_predict_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .d_is_br(d_is_br), .d_stall(d_stall), .d_pc(d_pc),
    .d_opcode(d_opcode), .d_rt(d_rt), .d_rd1(d_rd1), .d_rd2(d_rd2),
    .d_target(d_target), .d_pred_taken(d_pred_taken), .d_pred_target(d_pred_target),
    .br(br), .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] mtag(input logic [31:0] pc);
    return pc >> (2 + IDX_W);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    int i;
    i = midx(pc);
    return m_valid[i] && (m_tag[i] == mtag(pc)) && (m_cnt[i] >= HALF);
  endfunction

  function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
    return m_pred(pc) ? m_target[midx(pc)] : 32'd0;
  endfunction

  // Returns {recognised, condition} from the branch rules using signed arithmetic.
  function automatic logic [1:0] m_res(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'h04: return {1'b1, a == b};
      6'h05: return {1'b1, a != b};
      6'h06: return {1'b1, $signed(a) <= 0};
      6'h07: return {1'b1, $signed(a) > 0};
      6'h01: begin
        if (rt == 5'd0) return {1'b1, $signed(a) < 0};
        if (rt == 5'd1) return {1'b1, $signed(a) >= 0};
        return 2'b00;
      end
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_cnt[i] = HALF - 1;
    end
  endtask

  task automatic model_train();
    logic [1:0] r;
    int i;
    bit hit;
    r = m_res(d_opcode, d_rt, d_rd1, d_rd2);
    i = midx(d_pc);
    hit = m_valid[i] && (m_tag[i] == mtag(d_pc));
    if (!reset && d_is_br && !d_stall && r[1]) begin
      if (r[0]) begin
        m_cnt[i] = hit ? ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX) : HALF;
        m_valid[i] = 1'b1; m_tag[i] = mtag(d_pc); m_target[i] = d_target;
      end else if (hit && m_cnt[i] > 0) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
    end
  endtask

  task automatic step();
    model_train();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ib, input logic st, input logic [31:0] pc,
                       input logic [5:0] op, input logic [4:0] rt, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] tgt, input logic pt,
                       input logic [31:0] ptg);
    d_is_br = ib; d_stall = st; d_pc = pc; d_opcode = op; d_rt = rt;
    d_rd1 = r1; d_rd2 = r2; d_target = tgt; d_pred_taken = pt; d_pred_target = ptg;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 32'h1234, 6'h04, 5'd0, 32'd0, 32'd0, 32'h5000, 1'b0, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      f_pc = 32'h3000 + 32'(4 * i);
      #1;
      n_checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_lookup pc=%h got=%b/%h exp=0/0", f_pc, pred_taken, pred_target);
      end
    end
    n_checks++;
    if (br !== 1'b0 || mispredict !== 1'b0 || redirect_pc !== 32'h123c) begin
      n_fail++;
      $display("FAIL reset_resolve got br=%b mis=%b rpc=%h exp 0 0 0000123c", br, mispredict, redirect_pc);
    end
  endtask

  task automatic test_beq_train();
    drive(1'b1, 1'b0, 32'h3010, 6'h04, 5'd0, 32'd5, 32'd5, 32'h3040, 1'b0, 32'd0);
    f_pc = 32'h3010;
    #1;
    n_checks++;
    if (br !== 1'b1 || mispredict !== 1'b1 || redirect_pc !== 32'h3040 || pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_first got br=%b mis=%b rpc=%h pred=%b exp 1 1 00003040 0", br, mispredict, redirect_pc, pred_taken);
    end
    step();
    d_is_br = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h3040) begin
      n_fail++;
      $display("FAIL beq_learned got %b/%h exp 1/00003040", pred_taken, pred_target);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h3010, 6'h04, 5'd0, 32'd5, 32'd5, 32'h3040, 1'b1,
            (i == 2) ? 32'h3044 : 32'h3040);
      #1;
      n_checks++;
      if (br !== 1'b1 || mispredict !== (i == 2)) begin
        n_fail++;
        $display("FAIL beq_taken_%0d got br=%b mis=%b exp 1 %b", i, br, mispredict, i == 2);
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h3010, 6'h04, 5'd0, 32'd5, 32'd6, 32'h3040, 1'b1, 32'h3040);
      #1;
      n_checks++;
      if (br !== 1'b0 || mispredict !== 1'b1 || redirect_pc !== 32'h3018) begin
        n_fail++;
        $display("FAIL beq_nt_%0d got br=%b mis=%b rpc=%h exp 0 1 00003018", i, br, mispredict, redirect_pc);
      end
      step();
      d_is_br = 1'b0;
      #1;
      n_checks++;
      if (pred_taken !== (i == 0)) begin
        n_fail++;
        $display("FAIL beq_decay_%0d got pred=%b exp %b", i, pred_taken, i == 0);
      end
    end
  endtask

  task automatic test_sign_sweep();
    logic [5:0]  ops [4] = '{6'h07, 6'h06, 6'h01, 6'h01};
    logic [4:0]  rts [4] = '{5'd0, 5'd0, 5'd0, 5'd1};
    logic [31:0] rdv [3] = '{32'd0, 32'd1, 32'h8000_0000};
    bit          exp_tab [4][3] = '{'{0, 1, 0}, '{1, 0, 1}, '{0, 0, 1}, '{1, 1, 0}};
    for (int o = 0; o < 4; o++) begin
      for (int j = 0; j < 3; j++) begin
        drive(1'b1, 1'b1, 32'h3200, ops[o], rts[o], rdv[j], 32'd7, 32'h3300, 1'b0, 32'd0);
        #1;
        n_checks++;
        if (br !== exp_tab[o][j] || mispredict !== exp_tab[o][j] ||
            redirect_pc !== (exp_tab[o][j] ? 32'h3300 : 32'h3208)) begin
          n_fail++;
          $display("FAIL sign_sweep op=%h rt=%0d rd1=%h got br=%b mis=%b rpc=%h exp br=%b",
                   ops[o], rts[o], rdv[j], br, mispredict, redirect_pc, exp_tab[o][j]);
        end
      end
    end
    drive(1'b1, 1'b0, 32'h3200, 6'h23, 5'd0, 32'd3, 32'd3, 32'h3300, 1'b0, 32'd0);
    f_pc = 32'h3200;
    #1;
    n_checks++;
    if (br !== 1'b0 || mispredict !== 1'b0) begin
      n_fail++;
      $display("FAIL unknown_op got br=%b mis=%b exp 0 0", br, mispredict);
    end
    step();
    d_is_br = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL unknown_op_write got pred=%b exp 0", pred_taken);
    end
  endtask

  task automatic test_stall();
    f_pc = 32'h3100;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h3100, 6'h04, 5'd0, 32'd9, 32'd9, 32'h3200, 1'b0, 32'd0);
      #1;
      n_checks++;
      if (br !== 1'b1 || mispredict !== 1'b1 || pred_taken !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_%0d got br=%b mis=%b pred=%b exp 1 1 0", i, br, mispredict, pred_taken);
      end
      step();
    end
    d_stall = 1'b0;
    step();
    d_is_br = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h3200) begin
      n_fail++;
      $display("FAIL stall_release got %b/%h exp 1/00003200", pred_taken, pred_target);
    end
    drive(1'b1, 1'b0, 32'h3100, 6'h04, 5'd0, 32'd9, 32'd8, 32'h3200, 1'b1, 32'h3200);
    step();
    d_is_br = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_single_update got pred=%b exp 0", pred_taken);
    end
  endtask

  task automatic test_alias();
    logic [31:0] apc;
    apc = 32'h3010 + 32'(4 * DEPTH);
    drive(1'b1, 1'b0, apc, 6'h04, 5'd0, 32'd1, 32'd1, 32'h3500, 1'b0, 32'd0);
    step();
    d_is_br = 1'b0;
    f_pc = apc;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h3500) begin
      n_fail++;
      $display("FAIL alias_new got %b/%h exp 1/00003500", pred_taken, pred_target);
    end
    f_pc = 32'h3010;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL alias_old got pred=%b exp 0", pred_taken);
    end
    drive(1'b1, 1'b0, 32'h3010, 6'h05, 5'd0, 32'd1, 32'd1, 32'h3040, 1'b0, 32'd0);
    step();
    d_is_br = 1'b0;
    f_pc = apc;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL alias_nt_miss got pred=%b exp 1", pred_taken);
    end
  endtask

  function automatic logic [31:0] rand_rd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hffff_ffff;
      3: return 32'h7fff_ffff;
      4: return 32'h8000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [5:0] op_pool [7] = '{6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h23, 6'h00};
    logic [1:0] r;
    logic [31:0] pc, ptgt, exp_rpc;
    bit exp_br, exp_mis, pt;
    for (int n = 0; n < 600; n++) begin
      pc = 32'h3000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 2) << 8);
      pt = m_pred(pc);
      ptgt = m_ptarget(pc);
      if ($urandom_range(0, 3) == 0) begin
        pt = 1'($urandom);
        ptgt = ($urandom_range(0, 1) == 1) ? 32'h3000 + 32'($urandom_range(0, 3) << 4) : ptgt;
      end
      drive($urandom_range(0, 6) != 0, $urandom_range(0, 3) == 0, pc,
            op_pool[$urandom_range(0, 6)], 5'($urandom_range(0, 2)), rand_rd(), rand_rd(),
            32'h3000 + 32'($urandom_range(0, 3) << 4), pt, ptgt);
      if ($urandom_range(0, 1) == 1) d_rd2 = d_rd1;
      f_pc = ($urandom_range(0, 2) == 0) ? pc :
             32'h3000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 2) << 8);
      r = m_res(d_opcode, d_rt, d_rd1, d_rd2);
      exp_br = d_is_br && r[0];
      exp_mis = d_is_br && ((exp_br != d_pred_taken) ||
                            (exp_br && d_pred_taken && d_pred_target != d_target));
      exp_rpc = exp_br ? d_target : d_pc + 32'd8;
      #1;
      n_checks++;
      if (pred_taken !== m_pred(f_pc) || pred_target !== m_ptarget(f_pc)) begin
        n_fail++;
        $display("FAIL rand_lookup n=%0d pc=%h got %b/%h exp %b/%h", n, f_pc,
                 pred_taken, pred_target, m_pred(f_pc), m_ptarget(f_pc));
      end
      n_checks++;
      if (br !== exp_br || mispredict !== exp_mis || redirect_pc !== exp_rpc) begin
        n_fail++;
        $display("FAIL rand_resolve n=%0d op=%h rt=%0d rd1=%h rd2=%h got br=%b mis=%b rpc=%h exp %b %b %h",
                 n, d_opcode, d_rt, d_rd1, d_rd2, br, mispredict, redirect_pc, exp_br, exp_mis, exp_rpc);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 32'h3020, 6'h04, 5'd0, 32'd2, 32'd2, 32'h3600, 1'b0, 32'd0);
    step();
    f_pc = 32'h3020;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre got pred=%b exp 1", pred_taken);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin
      n_fail++;
      $display("FAIL async_clear got %b/%h exp 0/0", pred_taken, pred_target);
    end
    model_reset();
    step();
    reset = 1'b0;
    d_is_br = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL async_no_train got pred=%b exp 0", pred_taken);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_beq_train();
    test_sign_sweep();
    test_stall();
    test_alias();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
